// File: rtl/ofdm_tx_cp_inserter.sv
// OFDM transmit cyclic-prefix inserter: ping-pong buffers IFFT symbols and
// replays each as CP tail + full body, one sample per external rate strobe.
module ofdm_tx_cp_inserter #(
    parameter int sample_bit_width_g = 12,
    parameter int symbol_length_g    = 64,
    parameter int cp_length_g        = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic                          sys_init,
    input  logic [sample_bit_width_g-1:0] tx_symbol_i,
    input  logic [sample_bit_width_g-1:0] tx_symbol_q,
    input  logic                          tx_symbol_valid,
    output logic                          tx_symbol_ready,
    input  logic                          tx_data_strobe,
    output logic [sample_bit_width_g-1:0] tx_data_i,
    output logic [sample_bit_width_g-1:0] tx_data_q,
    output logic                          tx_data_valid,
    output logic                          tx_frame_start,
    output logic                          tx_underflow
);

    localparam int W  = sample_bit_width_g;
    localparam int N  = symbol_length_g;
    localparam int AW = $clog2(N);

    localparam logic [AW-1:0] CP_START_A  = AW'(N - cp_length_g);
    // Wraps to 0 when the CP is a single sample, which is exactly the BODY start.
    localparam logic [AW-1:0] CP_SECOND_A = AW'(N - cp_length_g + 1);
    localparam logic [AW-1:0] LAST_A      = AW'(N - 1);
    localparam logic [AW-1:0] ONE_A       = AW'(1);
    localparam logic [AW-1:0] ZERO_A      = AW'(0);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    logic [2*W-1:0] mem_q [2*N];

    rd_state_t      state_q, state_d;
    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, wr_bank_d;
    logic [AW-1:0]  wr_idx_q, wr_idx_d;
    logic           rd_bank_q, rd_bank_d;
    logic [AW-1:0]  rd_idx_q, rd_idx_d;
    logic           streaming_q, streaming_d;
    logic           ready_q, ready_d;
    logic [W-1:0]   data_i_q, data_i_d;
    logic [W-1:0]   data_q_q, data_q_d;
    logic           valid_q, valid_d;
    logic           frame_start_q, frame_start_d;
    logic           underflow_q, underflow_d;

    logic           wr_en_s;
    logic [AW-1:0]  rd_addr_s;
    logic [2*W-1:0] rd_word_s;

    assign rd_addr_s = (state_q == RD_IDLE) ? CP_START_A : rd_idx_q;
    assign rd_word_s = mem_q[{rd_bank_q, rd_addr_s}];

    // Sample RAM write port (no reset: contents are qualified by the full flags).
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            mem_q[{wr_bank_q, wr_idx_q}] <= {tx_symbol_i, tx_symbol_q};
        end
    end

    // Next-state logic for write side, read sequencer and output registers.
    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        wr_idx_d      = wr_idx_q;
        rd_bank_d     = rd_bank_q;
        rd_idx_d      = rd_idx_q;
        streaming_d   = streaming_q;
        data_i_d      = data_i_q;
        data_q_d      = data_q_q;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        wr_en_s       = 1'b0;

        if (tx_data_strobe) begin
            valid_d = 1'b1;
            case (state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        {data_i_d, data_q_d} = rd_word_s;
                        frame_start_d        = 1'b1;
                        streaming_d          = 1'b1;
                        rd_idx_d             = CP_SECOND_A;
                        state_d              = (CP_START_A == LAST_A) ? RD_BODY : RD_CP;
                    end else begin
                        data_i_d    = {W{1'b0}};
                        data_q_d    = {W{1'b0}};
                        underflow_d = streaming_q;
                    end
                end
                RD_CP: begin
                    {data_i_d, data_q_d} = rd_word_s;
                    frame_start_d        = (rd_idx_q == CP_START_A);
                    if (rd_idx_q == LAST_A) begin
                        rd_idx_d = ZERO_A;
                        state_d  = RD_BODY;
                    end else begin
                        rd_idx_d = rd_idx_q + ONE_A;
                    end
                end
                RD_BODY: begin
                    {data_i_d, data_q_d} = rd_word_s;
                    if (rd_idx_q == LAST_A) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        // Back-to-back symbols skip IDLE so the CP follows with no gap.
                        if (full_q[~rd_bank_q]) begin
                            rd_idx_d = CP_START_A;
                            state_d  = RD_CP;
                        end else begin
                            rd_idx_d = ZERO_A;
                            state_d  = RD_IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + ONE_A;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = RD_IDLE;
                end
            endcase
        end else begin
            valid_d = 1'b0;
        end

        if (tx_symbol_valid && ready_q) begin
            wr_en_s = 1'b1;
            if (wr_idx_q == LAST_A) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = ZERO_A;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + ONE_A;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        ready_d = ~full_d[wr_bank_d];

        if (sys_init) begin
            state_d       = RD_IDLE;
            full_d        = 2'b00;
            wr_bank_d     = 1'b0;
            wr_idx_d      = ZERO_A;
            rd_bank_d     = 1'b0;
            rd_idx_d      = ZERO_A;
            streaming_d   = 1'b0;
            ready_d       = 1'b1;
            data_i_d      = {W{1'b0}};
            data_q_d      = {W{1'b0}};
            valid_d       = 1'b0;
            frame_start_d = 1'b0;
            underflow_d   = 1'b0;
            wr_en_s       = 1'b0;
        end else begin
            streaming_d = streaming_d;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q       <= RD_IDLE;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= ZERO_A;
            rd_bank_q     <= 1'b0;
            rd_idx_q      <= ZERO_A;
            streaming_q   <= 1'b0;
            ready_q       <= 1'b1;
            data_i_q      <= {W{1'b0}};
            data_q_q      <= {W{1'b0}};
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            rd_bank_q     <= rd_bank_d;
            rd_idx_q      <= rd_idx_d;
            streaming_q   <= streaming_d;
            ready_q       <= ready_d;
            data_i_q      <= data_i_d;
            data_q_q      <= data_q_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign tx_symbol_ready = ready_q;
    assign tx_data_i       = data_i_q;
    assign tx_data_q       = data_q_q;
    assign tx_data_valid   = valid_q;
    assign tx_frame_start  = frame_start_q;
    assign tx_underflow    = underflow_q;

endmodule

// File: tb/tb_ofdm_tx_cp_inserter.sv
// Scoreboard bench for ofdm_tx_cp_inserter: directed symbol/strobe patterns,
// expected samples queued at stimulus time and checked by a negedge monitor.
module tb_ofdm_tx_cp_inserter;

    localparam int W  = 12;
    localparam int N  = 64;
    localparam int CP = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         init = 1'b0;
    logic [W-1:0] si = '0;
    logic [W-1:0] sq = '0;
    logic         sv = 1'b0;
    logic         strobe = 1'b0;
    logic         tx_symbol_ready;
    logic [W-1:0] tx_data_i;
    logic [W-1:0] tx_data_q;
    logic         tx_data_valid;
    logic         tx_frame_start;
    logic         tx_underflow;

    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic         fs;
        logic         uf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    ofdm_tx_cp_inserter #(
        .sample_bit_width_g(W),
        .symbol_length_g(N),
        .cp_length_g(CP)
    ) dut (
        .sys_clk(clk),
        .sys_rstn(rstn),
        .sys_init(init),
        .tx_symbol_i(si),
        .tx_symbol_q(sq),
        .tx_symbol_valid(sv),
        .tx_symbol_ready(tx_symbol_ready),
        .tx_data_strobe(strobe),
        .tx_data_i(tx_data_i),
        .tx_data_q(tx_data_q),
        .tx_data_valid(tx_data_valid),
        .tx_frame_start(tx_frame_start),
        .tx_underflow(tx_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        n_checks++;
        if (tx_data_valid) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got i=%0d q=%0d fs=%0b uf=%0b, required no sample",
                         $signed(tx_data_i), $signed(tx_data_q), tx_frame_start, tx_underflow);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tx_data_i, tx_data_q, tx_frame_start, tx_underflow} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sample @%0t: got i=%0d q=%0d fs=%0b uf=%0b, required i=%0d q=%0d fs=%0b uf=%0b",
                             $time, $signed(tx_data_i), $signed(tx_data_q), tx_frame_start, tx_underflow,
                             $signed(mon_e.i), $signed(mon_e.q), mon_e.fs, mon_e.uf);
                end
            end
        end else if (tx_frame_start || tx_underflow) begin
            n_fail++;
            $display("FAIL stray_flag: fs=%0b uf=%0b without valid, required 0", tx_frame_start, tx_underflow);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_sample(input int v, input logic fs);
        exp_t e;
        e.i  = W'(v);
        e.q  = W'(-v);
        e.fs = fs;
        e.uf = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_zero(input logic uf);
        exp_t e;
        e.i  = '0;
        e.q  = '0;
        e.fs = 1'b0;
        e.uf = uf;
        exp_q.push_back(e);
    endtask

    // First `count` output samples of a symbol whose sample k is base+k.
    task automatic push_frame(input int base, input int count);
        for (int n = 0; n < count; n++) begin
            if (n < CP) push_sample(base + N - CP + n, (n == 0));
            else        push_sample(base + n - CP, 1'b0);
        end
    endtask

    task automatic strobe_once(input int gap);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic write_one(input int base, input int k);
        int t;
        t  = 0;
        sv = 1'b1;
        si = W'(base + k);
        sq = W'(-(base + k));
        while (!tx_symbol_ready && t < 10000) begin
            tick();
            t++;
        end
        if (t >= 10000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles, required 1", t);
        end
        tick();
        sv = 1'b0;
    endtask

    task automatic write_symbol(input int base);
        for (int k = 0; k < N; k++) write_one(base, k);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data_i"}, 32'(tx_data_i), 0);
        chk({tag, "_data_q"}, 32'(tx_data_q), 0);
        chk({tag, "_valid"}, 32'(tx_data_valid), 0);
        chk({tag, "_frame_start"}, 32'(tx_frame_start), 0);
        chk({tag, "_underflow"}, 32'(tx_underflow), 0);
        chk({tag, "_ready"}, 32'(tx_symbol_ready), 1);
    endtask

    initial begin
        // Reset values, then one strobe with nothing buffered.
        repeat (3) tick();
        chk_idle_outputs("reset");
        rstn = 1'b1;
        tick();
        push_zero(1'b0);
        strobe = 1'b1;
        tick();
        chk("latency_valid", 32'(tx_data_valid), 1);
        strobe = 1'b0;
        init   = 1'b1;
        strobe = 1'b1;
        tick();
        init   = 1'b0;
        strobe = 1'b0;
        chk("init_ignores_strobe", 32'(tx_data_valid), 0);
        drain();

        // Single symbol I=k Q=-k, strobe every 25 clocks, then underflow.
        write_symbol(0);
        repeat (2) tick();
        push_frame(0, N + CP);
        push_zero(1'b1);
        for (int j = 0; j < N + CP + 1; j++) strobe_once(24);
        drain();

        // Three symbols back to back, slow strobe.
        pulse_init();
        write_symbol(0);
        write_symbol(100);
        chk("ready_low_after_two", 32'(tx_symbol_ready), 0);
        push_frame(0, N + CP);
        push_frame(100, N + CP);
        push_frame(200, N + CP);
        fork
            write_symbol(200);
            begin
                for (int j = 0; j < 3 * (N + CP); j++) begin
                    if (j == N + CP - 1) begin
                        chk("ready_before_release", 32'(tx_symbol_ready), 0);
                        strobe = 1'b1;
                        tick();
                        chk("ready_after_release", 32'(tx_symbol_ready), 1);
                        strobe = 1'b0;
                        repeat (24) tick();
                    end else begin
                        strobe_once(24);
                    end
                end
            end
        join
        drain();

        // Strobe every clock; second symbol completes in the release cycle.
        pulse_init();
        write_symbol(0);
        push_frame(0, N + CP);
        push_frame(100, N + CP);
        push_frame(200, N + CP);
        fork
            begin
                repeat (CP) tick();
                write_symbol(100);
                chk("ready_after_coincide", 32'(tx_symbol_ready), 1);
                write_symbol(200);
            end
            begin
                for (int j = 0; j < 3 * (N + CP); j++) strobe_once(0);
            end
        join
        drain();

        // Strobe in the cycle the bank becomes full yields zero.
        pulse_init();
        for (int k = 0; k < N - 1; k++) write_one(400, k);
        sv     = 1'b1;
        si     = W'(400 + N - 1);
        sq     = W'(-(400 + N - 1));
        strobe = 1'b1;
        push_zero(1'b0);
        tick();
        sv     = 1'b0;
        strobe = 1'b0;
        push_frame(400, N + CP);
        for (int j = 0; j < N + CP; j++) strobe_once(0);
        drain();

        // sys_init mid-BODY, then a clean frame.
        pulse_init();
        write_symbol(300);
        push_frame(300, 30);
        for (int j = 0; j < 30; j++) strobe_once(0);
        init   = 1'b1;
        strobe = 1'b1;
        tick();
        init   = 1'b0;
        strobe = 1'b0;
        chk_idle_outputs("midbody_init");
        drain();
        push_zero(1'b0);
        strobe_once(0);
        write_symbol(500);
        push_frame(500, N + CP);
        for (int j = 0; j < N + CP; j++) strobe_once(2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_tx_cp_inserter.md
Name: ofdm_tx_cp_inserter

Overview:
Transmit-side counterpart to the RX coarse alignment / CP removal stage. It takes time-domain OFDM symbols from the IFFT (symbol_length_g samples, burst at up to 1 sample/clock), buffers them in a ping-pong RAM and prepends a cyclic prefix. It then emits cp_length_g + symbol_length_g samples per symbol, paced by an external sample-rate strobe. Its output feeds the DAC / channel model at the same rate the RX path consumes rx_data.

Parameters:
sample_bit_width_g, 12, width of I and Q samples (two's complement)
symbol_length_g, 64, FFT size / useful samples per symbol (power of two)
cp_length_g, 16, cyclic prefix length; must satisfy 1 <= cp_length_g < symbol_length_g

Ports:
sys_clk  in  1  system clock
sys_rstn  in  1  asynchronous active-low reset
sys_init  in  1  synchronous clear, single-cycle pulse
tx_symbol_i  in  sample_bit_width_g  IFFT output, I component
tx_symbol_q  in  sample_bit_width_g  IFFT output, Q component
tx_symbol_valid  in  1  input sample valid; accepted only when tx_symbol_ready=1
tx_symbol_ready  out  1  a bank is free for writing
tx_data_strobe  in  1  one-cycle output sample-rate tick (nominally every 25 clocks)
tx_data_i  out  sample_bit_width_g  output sample, I component
tx_data_q  out  sample_bit_width_g  output sample, Q component
tx_data_valid  out  1  one-cycle pulse per output sample
tx_frame_start  out  1  high together with tx_data_valid on the first CP sample of each symbol
tx_underflow  out  1  one-cycle pulse: strobe served with a zero sample after the stream had started

Behaviour:
- Reset (sys_rstn=0, async): tx_data_i/q=0, tx_data_valid=0, tx_frame_start=0, tx_underflow=0, tx_symbol_ready=1, both banks empty, write bank=0, read state IDLE, streaming flag=0.
- sys_init=1: same values take effect on the next clock edge. tx_symbol_valid and tx_data_strobe in that cycle are ignored.
- Storage: 2 banks x symbol_length_g entries x 2*sample_bit_width_g bits; one full flag per bank.
- Write side:
  - Accepted sample is written at address wr_idx in the write bank; wr_idx increments.
  - At wr_idx = symbol_length_g-1: set that bank's full flag, wr_idx=0, toggle the write bank.
  - tx_symbol_ready = NOT full[write bank], registered. Never write into a full bank.
- Read states: IDLE, CP, BODY. All transitions happen only on a cycle with tx_data_strobe=1.
  - IDLE:
    - If full[read bank]: output sample at address symbol_length_g-cp_length_g, assert tx_frame_start, set streaming=1, go to CP with rd_idx = symbol_length_g-cp_length_g+1.
    - Otherwise: output 0/0 with tx_data_valid=1, and tx_underflow=1 if streaming=1.
  - CP: output sample at rd_idx, then rd_idx++. After emitting address symbol_length_g-1, go to BODY with rd_idx=0.
  - BODY: output sample at rd_idx, then rd_idx++. After emitting address symbol_length_g-1:
    - clear full[read bank] and toggle the read bank;
    - if the other bank's full flag is set, go directly to CP (next strobe emits its first CP sample with tx_frame_start, no gap);
    - otherwise go to IDLE.
- Latency: strobe in cycle t -> tx_data_valid/data/frame_start/underflow in cycle t+1 (registered RAM read). Outputs hold data between strobes; valid is a pulse.
- Simultaneous events:
  - A bank's full flag set in cycle t is visible to the read side from t+1. A strobe in cycle t in IDLE therefore emits zero.
  - A release in cycle t makes tx_symbol_ready=1 from t+1. A write completing a bank and the read side releasing the other bank in the same cycle are both honoured.
- A strobe every clock is legal; samples per symbol are exactly cp_length_g+symbol_length_g.
- streaming is cleared only by reset/sys_init. Gaps between bursts therefore report underflow by design.

Test Plan:
- Reset and sys_init -> all outputs at reset values, tx_symbol_ready=1; a strobe with no data gives tx_data_valid pulse with 0/0 and tx_underflow=0.
- One symbol with I=k, Q=-k (k=0..63), then strobe every 25 clocks -> 80 valid pulses with I sequence 48..63 then 0..63; tx_frame_start only on the first; 81st strobe gives 0 with tx_underflow=1.
- Three symbols written back to back -> tx_symbol_ready falls after the second symbol's 64th sample and rises one cycle after the first symbol's last BODY strobe; output is 240 contiguous samples with tx_frame_start at samples 0, 80 and 160.
- Strobe every clock with symbols written at 1 sample/clock -> no zero samples and no underflow; the fill/release coincidence cycle is handled correctly.
- Strobe in the same cycle a bank becomes full (IDLE) -> that strobe yields 0; the next strobe yields the address-48 sample with tx_frame_start.
- sys_init pulsed mid-BODY (after 30 output samples) -> next cycle outputs and flags cleared; a fresh symbol afterwards produces a clean 80-sample frame, and no underflow on the first idle strobe.
